// File: rtl/seven_seg_ctrl_if.sv
// Request side of the seven-segment controller: value, format flags and valid/ready handshake.
// The master (LSU display register) drives the request; the slave (controller) answers ready.
interface seven_seg_ctrl_if #(
    parameter int DATA_W = 32
) ();
    logic [DATA_W-1:0] data;
    logic              mode;
    logic              blank;
    logic              valid;
    logic              ready;

    modport master (output data, mode, blank, valid, input ready);
    modport slave  (input data, mode, blank, valid, output ready);
endinterface

// File: rtl/seven_seg_ctrl.sv
// Registered seven-segment display controller: hex or decimal (sequential double-dabble)
// rendering with leading-zero blanking and overflow dashes, up to eight digits.
module seven_seg_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int DATA_W     = 32,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    seven_seg_ctrl_if.slave         req_if,
    output logic                    done_o,
    output logic                    overflow_o,
    output logic [7*NUM_DIGITS-1:0] hex_o
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int EXT_W = (DATA_W > BCD_W) ? DATA_W : BCD_W;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [6:0] BLANK_SEG = 7'h7F;
    localparam logic [6:0] DASH_SEG  = 7'h3F;
    localparam logic [6:0] BLANK_OUT = (ACTIVE_LOW != 0) ? BLANK_SEG : ~BLANK_SEG;

    typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_e;

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [BCD_W-1:0]        bcd_q;
    logic [DATA_W-1:0]       shf_q;
    logic                    blank_q;
    logic                    ovf_q;
    logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
    logic                    done_q;
    logic                    ovf_out_q;

    // Active-low segment pattern, bit 0 = segment a.
    function automatic logic [6:0] seg_lut(input logic [3:0] nib);
        case (nib)
            4'h0: seg_lut = 7'h40;  4'h1: seg_lut = 7'h79;
            4'h2: seg_lut = 7'h24;  4'h3: seg_lut = 7'h30;
            4'h4: seg_lut = 7'h19;  4'h5: seg_lut = 7'h12;
            4'h6: seg_lut = 7'h02;  4'h7: seg_lut = 7'h78;
            4'h8: seg_lut = 7'h00;  4'h9: seg_lut = 7'h10;
            4'hA: seg_lut = 7'h08;  4'hB: seg_lut = 7'h03;
            4'hC: seg_lut = 7'h46;  4'hD: seg_lut = 7'h21;
            4'hE: seg_lut = 7'h06;  default: seg_lut = 7'h0E;
        endcase
    endfunction

    // One double-dabble step: correct nibbles, then shift {bcd, data} left by one.
    logic [BCD_W-1:0]  bcd_adj, bcd_shf;
    logic [DATA_W-1:0] shf_shf;
    logic              shift_out;

    // NOTE: combinational blocks use blocking '=' and assign every output a default first,
    // so no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
        {shift_out, bcd_shf, shf_shf} = {bcd_adj, shf_q, 1'b0};
    end

    // Hex path: nibbles straight from data; any bit above the display width is overflow.
    logic [EXT_W-1:0] data_ext;
    logic [BCD_W-1:0] hex_load;
    logic             hex_ovf;

    always_comb begin
        data_ext = EXT_W'(req_if.data);
        hex_load = data_ext[BCD_W-1:0];
        hex_ovf  = 1'b0;
        for (int i = BCD_W; i < EXT_W; i++) hex_ovf = hex_ovf | data_ext[i];
    end

    // Render digits from the top down so blanking stops at the first nonzero digit.
    logic       leading;
    logic [3:0] nib;
    logic [6:0] code;

    always_comb begin
        hex_d   = '0;
        leading = blank_q;
        nib     = '0;
        code    = BLANK_SEG;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            nib = bcd_q[4*k +: 4];
            if (ovf_q) begin
                code = DASH_SEG;
            end else if (leading && (k != 0) && (nib == 4'd0)) begin
                code = BLANK_SEG;
            end else begin
                code    = seg_lut(nib);
                leading = 1'b0;
            end
            hex_d[7*k +: 7] = (ACTIVE_LOW != 0) ? code : ~code;
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bcd_q     <= '0;
            shf_q     <= '0;
            blank_q   <= 1'b0;
            ovf_q     <= 1'b0;
            hex_q     <= {NUM_DIGITS{BLANK_OUT}};
            done_q    <= 1'b0;
            ovf_out_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_if.valid) begin
                        blank_q <= req_if.blank;
                        if (req_if.mode) begin
                            state_q <= CONV;
                            cnt_q   <= CNT_W'(DATA_W);
                            bcd_q   <= '0;
                            shf_q   <= req_if.data;
                            ovf_q   <= 1'b0;
                        end else begin
                            state_q <= UPDATE;
                            bcd_q   <= hex_load;
                            ovf_q   <= hex_ovf;
                        end
                    end
                end
                CONV: begin
                    bcd_q <= bcd_shf;
                    shf_q <= shf_shf;
                    ovf_q <= ovf_q | shift_out;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_q <= UPDATE;
                end
                UPDATE: begin
                    hex_q     <= hex_d;
                    ovf_out_q <= ovf_q;
                    done_q    <= 1'b1;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_if.ready = (state_q == IDLE);
    assign done_o       = done_q;
    assign overflow_o   = ovf_out_q;
    assign hex_o        = hex_q;
endmodule

// File: tb/tb_seven_seg_ctrl.sv
// Self-checking bench: an 8-digit active-low and a 4-digit active-high controller receive
// identical requests and are compared against a div/mod reference model.
module tb_seven_seg_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seven_seg_ctrl_if #(.DATA_W(32)) if8 ();
    seven_seg_ctrl_if #(.DATA_W(32)) if4 ();

    logic        done8, ovf8, done4, ovf4;
    logic [55:0] hex8;
    logic [27:0] hex4;

    assign if4.data  = if8.data;
    assign if4.mode  = if8.mode;
    assign if4.blank = if8.blank;
    assign if4.valid = if8.valid;

    seven_seg_ctrl #(.NUM_DIGITS(8), .DATA_W(32), .ACTIVE_LOW(1)) dut8 (
        .clk_i(clk), .rst_ni(rst_n), .req_if(if8), .done_o(done8), .overflow_o(ovf8), .hex_o(hex8));
    seven_seg_ctrl #(.NUM_DIGITS(4), .DATA_W(32), .ACTIVE_LOW(0)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .req_if(if4), .done_o(done4), .overflow_o(ovf4), .hex_o(hex4));

    int n_checks = 0;
    int n_errors = 0;
    logic [55:0] exp8;
    logic [27:0] exp4;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: digits by repeated div/mod in the chosen base; overflow if anything is left.
    function automatic logic [55:0] model(input logic [31:0] v, input bit m, input bit b,
                                          input int nd, input bit al, output bit ovf);
        logic [6:0]      seg [16];
        longint unsigned val;
        int unsigned     base, top;
        int unsigned     dig [8];
        logic [6:0]      c;
        logic [55:0]     r;
        seg = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        val  = longint'(v);
        base = m ? 10 : 16;
        r    = '0;
        top  = 0;
        for (int k = 0; k < nd; k++) begin
            dig[k] = int'(val % base);
            val    = val / base;
            if (dig[k] != 0) top = k;
        end
        ovf = (val != 0);
        for (int k = 0; k < nd; k++) begin
            if (ovf) c = 7'h3F;
            else if (b && k > top) c = 7'h7F;
            else c = seg[dig[k]];
            r[7*k +: 7] = al ? c : ~c;
        end
        return r;
    endfunction

    task automatic idle_cycle();
        @(negedge clk);
        check("done_single_pulse", {done8, done4}, 2'b00);
    endtask

    // Called at a negedge with the controllers idle; returns at the negedge of the done cycle.
    task automatic do_req(input string tag, input logic [31:0] v, input bit m, input bit b,
                          input bit noise);
        int          lat;
        bit          stable, busy_ok, o8, o4;
        logic [55:0] e8, full4;
        check({tag, "_ready_before"}, {if8.ready, if4.ready}, 2'b11);
        if8.valid = 1'b1; if8.data = v; if8.mode = m; if8.blank = b;
        @(posedge clk);
        @(negedge clk);
        if8.valid = 1'b0;
        if8.data  = $urandom;
        check({tag, "_done_low_T1"}, {done8, done4}, 2'b00);
        lat = 0; stable = 1'b1; busy_ok = 1'b1;
        while (done8 !== 1'b1 && lat < 100) begin
            if (hex8 !== exp8 || hex4 !== exp4) stable = 1'b0;
            if (if8.ready !== 1'b0 || if4.ready !== 1'b0 || done4 !== 1'b0) busy_ok = 1'b0;
            if (noise && m) begin
                if8.valid = (lat < 20);
                if8.data  = $urandom;
                if8.mode  = 1'($urandom);
                if8.blank = 1'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        if8.valid = 1'b0;
        e8    = model(v, m, b, 8, 1'b1, o8);
        full4 = model(v, m, b, 4, 1'b0, o4);
        check({tag, "_latency"}, 64'(lat), m ? 64'd33 : 64'd1);
        check({tag, "_hex_held"}, 64'(stable), 64'd1);
        check({tag, "_busy"}, 64'(busy_ok), 64'd1);
        check({tag, "_hex8"}, 64'(hex8), 64'(e8));
        check({tag, "_ovf8"}, 64'(ovf8), 64'(o8));
        check({tag, "_hex4"}, 64'(hex4), 64'(full4[27:0]));
        check({tag, "_ovf4"}, 64'(ovf4), 64'(o4));
        check({tag, "_done4_ready"}, {done4, if8.ready, if4.ready}, 3'b111);
        exp8 = e8;
        exp4 = full4[27:0];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_done;
        rst_n = 1'b0;
        if8.valid = 1'b0; if8.data = '0; if8.mode = 1'b0; if8.blank = 1'b0;
        exp8 = {8{7'h7F}};
        exp4 = '0;
        @(negedge clk);
        check("rst_hex8", 64'(hex8), 64'({8{7'h7F}}));
        check("rst_hex4", 64'(hex4), 64'd0);
        check("rst_flags", {if8.ready, if4.ready, done8, done4, ovf8, ovf4}, 6'b110000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_req("hex_1234abcd", 32'h1234ABCD, 1'b0, 1'b0, 1'b0);
        idle_cycle();
        do_req("dec_42_blank", 32'd42, 1'b1, 1'b1, 1'b0);
        idle_cycle();
        do_req("dec_overflow", 32'd100000000, 1'b1, 1'b0, 1'b0);
        idle_cycle();
        do_req("hex_10000", 32'h00010000, 1'b0, 1'b1, 1'b0);
        do_req("hex_b2b", 32'h0000BEEF, 1'b0, 1'b1, 1'b0);
        idle_cycle();
        do_req("dec_0_noise", 32'd0, 1'b1, 1'b1, 1'b1);
        idle_cycle();
        do_req("dec_max", 32'd99999999, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            logic [31:0] v;
            case ($urandom_range(0, 3))
                0: v = $urandom;
                1: v = $urandom_range(0, 99999);
                2: v = $urandom_range(0, 15);
                default: v = $urandom_range(0, 99999999);
            endcase
            if ($urandom_range(0, 1) == 0) idle_cycle();
            do_req("rand", v, 1'($urandom), 1'($urandom), 1'($urandom));
        end

        // Reset in the middle of a decimal conversion.
        idle_cycle();
        if8.valid = 1'b1; if8.data = 32'd12345; if8.mode = 1'b1; if8.blank = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if8.valid = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midconv_hex8", 64'(hex8), 64'({8{7'h7F}}));
        check("midconv_hex4", 64'(hex4), 64'd0);
        check("midconv_flags", {if8.ready, if4.ready, done8, done4, ovf8, ovf4}, 6'b110000);
        exp8 = {8{7'h7F}};
        exp4 = '0;
        seen_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done8 || done4) seen_done = 1'b1;
        end
        rst_n = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (done8 || done4) seen_done = 1'b1;
        end
        check("midconv_no_done", 64'(seen_done), 64'd0);
        do_req("after_reset", 32'd7654321, 1'b1, 1'b1, 1'b0);
        idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
